wb_pipe_responder: RTL and testbench

//  Pipelined Wishbone (B4) slave responder: the slave end of the bus the ZipCPU

---
 rtl/wb_pipe_responder_pkg.sv | 19 +
 rtl/wb_pipe_responder_if.sv | 29 ++
 rtl/wb_resp_pipe.sv | 49 ++++
 rtl/wb_pipe_responder.sv | 105 ++++++++++
 tb/tb_wb_pipe_responder.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pipe_responder_pkg.sv
// Shared types and helpers for the pipelined Wishbone responder.
// A response travels as a {valid, err} tag plus a data word.
package wb_pipe_responder_pkg;

  localparam int WB_BYTE_W = 8;
  localparam int PCNT_W    = 3;

  typedef struct packed {
    logic vld;
    logic err;
  } resp_tag_t;

  // Word address lies inside a 2**lgmem deep memory
  function automatic logic addr_in_range(input logic [31:0] addr, input int lgmem);
    if (lgmem >= 32) return 1'b1;
    return (addr >> lgmem) == 32'd0;
  endfunction

endpackage

// File: rtl/wb_pipe_responder_if.sv
// Pipelined Wishbone B4 bus bundle; master drives requests, slave responds.
interface wb_pipe_responder_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  import wb_pipe_responder_pkg::*;

  logic                      i_wb_cyc;
  logic                      i_wb_stb;
  logic                      i_wb_we;
  logic [AW-1:0]             i_wb_addr;
  logic [DW-1:0]             i_wb_data;
  logic [DW/WB_BYTE_W-1:0]   i_wb_sel;
  logic                      o_wb_stall;
  logic                      o_wb_ack;
  logic [DW-1:0]             o_wb_data;
  logic                      o_wb_err;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    input  o_wb_stall, o_wb_ack, o_wb_data, o_wb_err
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    output o_wb_stall, o_wb_ack, o_wb_data, o_wb_err
  );

endinterface

// File: rtl/wb_resp_pipe.sv
// LATENCY-deep response shift register; stage 0 loads on the accept edge,
// the last stage drives the bus. A flush drops every in-flight response.
module wb_resp_pipe
  import wb_pipe_responder_pkg::*;
#(
  parameter int DW      = 32,
  parameter int LATENCY = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_flush,
  input  resp_tag_t     i_tag,
  input  logic [DW-1:0] i_data,
  output resp_tag_t     o_tag,
  output logic [DW-1:0] o_data
);

  resp_tag_t [LATENCY-1:0]         tag_q, tag_d;
  logic      [LATENCY-1:0][DW-1:0] data_q, data_d;

  always_comb begin
    tag_d     = tag_q;
    data_d    = data_q;
    tag_d[0]  = i_tag;
    data_d[0] = i_data;
    for (int s = 1; s < LATENCY; s++) begin
      tag_d[s]  = tag_q[s-1];
      data_d[s] = data_q[s-1];
    end
    // Only valids are cleared; stale data behind a cleared valid is harmless
    if (i_flush) begin
      for (int s = 0; s < LATENCY; s++) tag_d[s].vld = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tag_q  <= '0;
      data_q <= '0;
    end else begin
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

  assign o_tag  = tag_q[LATENCY-1];
  assign o_data = data_q[LATENCY-1];

endmodule

// File: rtl/wb_pipe_responder.sv
// Pipelined Wishbone slave backed by a small word memory: fixed-latency
// ACK/ERR, programmable stall pattern, stall when the outstanding count is full.
module wb_pipe_responder
  import wb_pipe_responder_pkg::*;
#(
  parameter int          AW         = 8,
  parameter int          DW         = 32,
  parameter int          LGMEM      = 4,
  parameter int          LATENCY    = 2,
  parameter int          LGDEPTH    = 3,
  parameter logic [7:0]  STALL_MASK = 8'h00
) (
  input logic               i_clk,
  input logic               i_reset,
  wb_pipe_responder_if.slave wb
);

  localparam int SW   = DW / WB_BYTE_W;
  localparam int MEMW = 1 << LGMEM;

  if (STALL_MASK == 8'hFF) begin : g_bad_mask
    $error("wb_pipe_responder: STALL_MASK of all ones would stall forever");
  end
  if (LATENCY < 1) begin : g_bad_lat
    $error("wb_pipe_responder: LATENCY must be at least 1");
  end
  if (LGMEM > AW || AW > 32) begin : g_bad_aw
    $error("wb_pipe_responder: need LGMEM <= AW <= 32");
  end

  logic [DW-1:0]      mem_q [MEMW];
  logic [LGDEPTH-1:0] cnt_q, cnt_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;

  logic               cyc, stall, accept, in_range, full, resp_done;
  logic [LGMEM-1:0]   idx;
  logic [DW-1:0]      rd_data;
  resp_tag_t          req_tag, rsp_tag;
  logic [DW-1:0]      rsp_data;

  assign cyc      = wb.i_wb_cyc;
  assign idx      = wb.i_wb_addr[LGMEM-1:0];
  assign in_range = addr_in_range(32'(wb.i_wb_addr), LGMEM);
  assign full     = (cnt_q == {LGDEPTH{1'b1}});
  // Stall is combinational so the master sees it in the same cycle as stb
  assign stall    = !i_reset && cyc && (full || STALL_MASK[pcnt_q]);
  assign accept   = cyc && wb.i_wb_stb && !stall;

  // Memory is deliberately not reset; writes commit on the accept edge
  always_ff @(posedge i_clk) begin
    if (accept && wb.i_wb_we && in_range) begin
      for (int b = 0; b < SW; b++) begin
        if (wb.i_wb_sel[b]) mem_q[idx][b*WB_BYTE_W +: WB_BYTE_W] <= wb.i_wb_data[b*WB_BYTE_W +: WB_BYTE_W];
      end
    end
  end

  // Read data is captured at accept, so it already reflects earlier writes
  assign rd_data     = (!wb.i_wb_we && in_range) ? mem_q[idx] : '0;
  assign req_tag.vld = accept;
  assign req_tag.err = !in_range;

  wb_resp_pipe #(
    .DW      (DW),
    .LATENCY (LATENCY)
  ) u_pipe (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_flush (!cyc),
    .i_tag   (req_tag),
    .i_data  (rd_data),
    .o_tag   (rsp_tag),
    .o_data  (rsp_data)
  );

  assign resp_done = rsp_tag.vld;

  always_comb begin
    cnt_d = cnt_q;
    if (!cyc)                        cnt_d = '0;
    else if (accept && !resp_done)   cnt_d = cnt_q + LGDEPTH'(1);
    else if (!accept && resp_done)   cnt_d = cnt_q - LGDEPTH'(1);
  end

  always_comb begin
    pcnt_d = '0;
    if (cyc) pcnt_d = pcnt_q + PCNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q  <= '0;
      pcnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pcnt_q <= pcnt_d;
    end
  end

  assign wb.o_wb_stall = stall;
  assign wb.o_wb_ack   = rsp_tag.vld && !rsp_tag.err;
  assign wb.o_wb_err   = rsp_tag.vld &&  rsp_tag.err;
  assign wb.o_wb_data  = rsp_data;

endmodule

// File: tb/tb_wb_pipe_responder.sv
// Scoreboard bench for wb_pipe_responder: three configurations, directed
// requests push expected responses; a negedge monitor pops and compares.
module tb_wb_pipe_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  cyc_r  = '0;
  logic [2:0]  stb_r  = '0;
  logic        we_r   = 1'b0;
  logic [7:0]  addr_r = '0;
  logic [31:0] wdat_r = '0;
  logic [3:0]  sel_r  = '0;

  logic [2:0]  stall_w, ack_w, err_w;
  logic [31:0] data_w [3];

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  wb_pipe_responder_if #(.AW(8), .DW(32)) wb0 ();
  wb_pipe_responder_if #(.AW(8), .DW(32)) wb1 ();
  wb_pipe_responder_if #(.AW(8), .DW(32)) wb2 ();

  assign wb0.i_wb_cyc = cyc_r[0];  assign wb0.i_wb_stb = stb_r[0];
  assign wb1.i_wb_cyc = cyc_r[1];  assign wb1.i_wb_stb = stb_r[1];
  assign wb2.i_wb_cyc = cyc_r[2];  assign wb2.i_wb_stb = stb_r[2];
  assign wb0.i_wb_we = we_r;  assign wb0.i_wb_addr = addr_r;  assign wb0.i_wb_data = wdat_r;  assign wb0.i_wb_sel = sel_r;
  assign wb1.i_wb_we = we_r;  assign wb1.i_wb_addr = addr_r;  assign wb1.i_wb_data = wdat_r;  assign wb1.i_wb_sel = sel_r;
  assign wb2.i_wb_we = we_r;  assign wb2.i_wb_addr = addr_r;  assign wb2.i_wb_data = wdat_r;  assign wb2.i_wb_sel = sel_r;

  assign stall_w[0] = wb0.o_wb_stall;  assign ack_w[0] = wb0.o_wb_ack;  assign err_w[0] = wb0.o_wb_err;  assign data_w[0] = wb0.o_wb_data;
  assign stall_w[1] = wb1.o_wb_stall;  assign ack_w[1] = wb1.o_wb_ack;  assign err_w[1] = wb1.o_wb_err;  assign data_w[1] = wb1.o_wb_data;
  assign stall_w[2] = wb2.o_wb_stall;  assign ack_w[2] = wb2.o_wb_ack;  assign err_w[2] = wb2.o_wb_err;  assign data_w[2] = wb2.o_wb_data;

  wb_pipe_responder #(.AW(8), .DW(32), .LGMEM(4), .LATENCY(2), .LGDEPTH(3), .STALL_MASK(8'h00))
    u0 (.i_clk(clk), .i_reset(rst), .wb(wb0));
  wb_pipe_responder #(.AW(8), .DW(32), .LGMEM(4), .LATENCY(2), .LGDEPTH(3), .STALL_MASK(8'h0C))
    u1 (.i_clk(clk), .i_reset(rst), .wb(wb1));
  wb_pipe_responder #(.AW(8), .DW(32), .LGMEM(4), .LATENCY(4), .LGDEPTH(2), .STALL_MASK(8'h00))
    u2 (.i_clk(clk), .i_reset(rst), .wb(wb2));

  typedef struct {
    int          k;
    logic        err;
    logic        chk;
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  exp_t sbq[$];
  chk_t chq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat [3] = '{2, 2, 4};

  // Monitor: the only process that compares and steps the counters
  always @(negedge clk) begin
    exp_t e;
    chk_t c;
    for (int k = 0; k < 3; k++) begin
      if (ack_w[k] || err_w[k]) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL resp_unexpected dut%0d cycle %0d: got ack=%0b err=%0b, want none", k, cyc_n, ack_w[k], err_w[k]);
        end else begin
          e = sbq.pop_front();
          if (e.k != k || e.due != cyc_n || err_w[k] !== e.err || ack_w[k] !== !e.err ||
              (e.chk && data_w[k] !== e.data)) begin
            n_bad++;
            $display("FAIL resp dut%0d cycle %0d: got ack=%0b err=%0b data=%h, want dut%0d cycle %0d err=%0b data=%h",
                     k, cyc_n, ack_w[k], err_w[k], data_w[k], e.k, e.due, e.err, e.data);
          end
        end
      end
    end
    if (sbq.size() > 0 && sbq[0].due < cyc_n) begin
      e = sbq.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL resp_missing dut%0d: got nothing at cycle %0d, want response", e.k, e.due);
    end
    while (chq.size() > 0) begin
      c = chq.pop_front();
      n_cmp++;
      if (c.act !== c.exp) begin
        n_bad++;
        $display("FAIL %s: got %0h want %0h", c.name, c.act, c.exp);
      end
    end
  end

  task automatic push_chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = name; c.act = act; c.exp = exp;
    chq.push_back(c);
  endtask

  task automatic purge(input int k, input int lim);
    for (int i = sbq.size() - 1; i >= 0; i--)
      if (sbq[i].k == k && sbq[i].due >= lim) sbq.delete(i);
  endtask

  // Called at posedge+1; returns at the posedge+1 after the accept edge
  task automatic req(input int k, input logic we, input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic eerr, input logic chk,
                     input logic [31:0] edata, output int stalls);
    exp_t e;
    cyc_r[k] = 1'b1; stb_r[k] = 1'b1;
    we_r = we; addr_r = a; wdat_r = d; sel_r = s;
    stalls = 0;
    @(negedge clk);
    while (stall_w[k] && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    if (stall_w[k]) push_chk("stall_timeout", 32'(stalls), 32'd0);
    else begin
      e.k = k; e.err = eerr; e.chk = chk; e.data = edata; e.due = cyc_n + lat[k];
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    stb_r[k] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int st;
    int st4 [4];
    logic [31:0] burst_exp [4];
    burst_exp = '{32'hA0A0A0A0, 32'h11111111, 32'h22222222, 32'hFFFF5678};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    push_chk("rst_ack",   32'(ack_w),   32'd0);
    push_chk("rst_err",   32'(err_w),   32'd0);
    push_chk("rst_stall", 32'(stall_w), 32'd0);
    push_chk("rst_data",  data_w[0],    32'd0);
    push_chk("rst_cnt",   32'(u0.cnt_q), 32'd0);

    // Byte-lane write then read right behind it in the pipeline
    req(0, 1'b1, 8'd3, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0, 32'd0, st);
    req(0, 1'b1, 8'd3, 32'h12345678, 4'b0011, 1'b0, 1'b0, 32'd0, st);
    req(0, 1'b0, 8'd3, 32'd0, 4'hF, 1'b0, 1'b1, 32'hFFFF5678, st);

    req(0, 1'b1, 8'd0, 32'hA0A0A0A0, 4'hF, 1'b0, 1'b0, 32'd0, st);
    req(0, 1'b1, 8'd1, 32'h11111111, 4'hF, 1'b0, 1'b0, 32'd0, st);
    req(0, 1'b1, 8'd2, 32'h22222222, 4'hF, 1'b0, 1'b0, 32'd0, st);
    for (int i = 0; i < 4; i++) begin
      req(0, 1'b0, 8'(i), 32'd0, 4'hF, 1'b0, 1'b1, burst_exp[i], st4[i]);
    end
    for (int i = 0; i < 4; i++) push_chk("burst_stall", 32'(st4[i]), 32'd0);
    repeat (3) @(posedge clk);
    #1 push_chk("burst_cnt", 32'(u0.cnt_q), 32'd0);

    req(0, 1'b1, 8'd5, 32'h00000000, 4'hF, 1'b0, 1'b0, 32'd0, st);
    req(0, 1'b1, 8'd5, 32'hCAFEBABE, 4'b1010, 1'b0, 1'b0, 32'd0, st);
    req(0, 1'b0, 8'd5, 32'd0, 4'hF, 1'b0, 1'b1, 32'hCA00BA00, st);

    // Out of range: err with zero data, no aliasing write into word 0
    req(0, 1'b1, 8'd16,  32'hDEADBEEF, 4'hF, 1'b1, 1'b1, 32'd0, st);
    req(0, 1'b0, 8'd16,  32'd0, 4'hF, 1'b1, 1'b1, 32'd0, st);
    req(0, 1'b0, 8'hFF,  32'd0, 4'hF, 1'b1, 1'b1, 32'd0, st);
    req(0, 1'b0, 8'd0,   32'd0, 4'hF, 1'b0, 1'b1, 32'hA0A0A0A0, st);
    repeat (3) @(posedge clk);
    #1 cyc_r[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset with two writes in flight
    req(0, 1'b1, 8'd8, 32'h88888888, 4'hF, 1'b0, 1'b0, 32'd0, st);
    req(0, 1'b1, 8'd9, 32'h99999999, 4'hF, 1'b0, 1'b0, 32'd0, st);
    purge(0, cyc_n);
    rst = 1'b1;
    #1;
    push_chk("midrst_ack",   32'(ack_w[0]),   32'd0);
    push_chk("midrst_err",   32'(err_w[0]),   32'd0);
    push_chk("midrst_stall", 32'(stall_w[0]), 32'd0);
    push_chk("midrst_cnt",   32'(u0.cnt_q),   32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 push_chk("postrst_cnt", 32'(u0.cnt_q), 32'd0);
    cyc_r[0] = 1'b0;
    @(posedge clk); #1;

    // Stall pattern 8'h0C: stb raised at pcnt 2 stalls through pcnt 3
    cyc_r[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req(1, 1'b1, 8'd5, 32'h55555555, 4'hF, 1'b0, 1'b0, 32'd0, st);
    push_chk("pat_stalls", 32'(st), 32'd2);
    push_chk("pat_pcnt_after", 32'(u1.pcnt_q), 32'd5);
    req(1, 1'b1, 8'd6, 32'h66666666, 4'hF, 1'b0, 1'b0, 32'd0, st);
    push_chk("pat_nostall", 32'(st), 32'd0);
    repeat (4) @(posedge clk);
    #1 cyc_r[1] = 1'b0;
    @(posedge clk); #1;

    // Outstanding limit 3 with LATENCY 4, then abort mid-pipe
    cyc_r[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req(2, 1'b1, 8'(i), 32'h0 + 32'(i), 4'hF, 1'b0, 1'b0, 32'd0, st4[i]);
      if (i == 2) push_chk("depth_cnt_full", 32'(u2.cnt_q), 32'd3);
    end
    push_chk("depth_st0", 32'(st4[0]), 32'd0);
    push_chk("depth_st1", 32'(st4[1]), 32'd0);
    push_chk("depth_st2", 32'(st4[2]), 32'd0);
    push_chk("depth_st3", 32'(st4[3]), 32'd2);
    cyc_r[2] = 1'b0;
    purge(2, cyc_n + 1);
    @(posedge clk); #1;
    push_chk("abort_ack", 32'(ack_w[2]), 32'd0);
    push_chk("abort_err", 32'(err_w[2]), 32'd0);
    push_chk("abort_cnt", 32'(u2.cnt_q), 32'd0);
    repeat (8) @(posedge clk);
    #1 push_chk("sb_drained", 32'(sbq.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
